// File: rtl/node_stripe_mac.sv
// node_stripe_mac: LANES signed fixed-point lanes fed by one tag-matching front end.
// Latency: result registered on the edge that ends the final COMPUTE. Each iteration
// takes one GATHER beat pair plus one COMPUTE cycle.
// Backpressure: out_valid/out_data/out_sat hold until out_ready. cfg_ready is low
// while busy. Bus beats are snooped, never stalled.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   cfg_valid/cfg_ready        job descriptor handshake
//   cfg_op, cfg_acc            operation select, accumulate (1) or overwrite (0)
//   cfg_tag_*, cfg_stride_*    A/B start tags and per-iteration tag strides
//   cfg_count                  iteration count (0 gives an immediate zero result)
//   bus_valid/tag/data         broadcast operand bus; lane i = data[i*DATA_W +: DATA_W]
//   out_valid/ready/data/sat   rounded, saturated result with per-lane saturation flags
//   busy                       high whenever the FSM is not idle
module node_stripe_mac #(
  parameter int LANES  = 8,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40,
  parameter int TAG_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [1:0]              cfg_op,
  input  logic                    cfg_acc,
  input  logic [TAG_W-1:0]        cfg_tag_a,
  input  logic [TAG_W-1:0]        cfg_tag_b,
  input  logic [TAG_W-1:0]        cfg_stride_a,
  input  logic [TAG_W-1:0]        cfg_stride_b,
  input  logic [TAG_W-1:0]        cfg_count,
  input  logic                    bus_valid,
  input  logic [TAG_W-1:0]        bus_tag,
  input  logic [LANES*DATA_W-1:0] bus_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_sat,
  output logic                    busy
);

  typedef enum logic [1:0] {S_IDLE, S_GATHER, S_COMPUTE, S_DRAIN} state_t;

  // Rounding constant: half an output LSB in accumulator units.
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC_W - 1);

  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic                    acc_mode_q, acc_mode_d;
  logic [TAG_W-1:0]        tag_a_q, tag_a_d, tag_b_q, tag_b_d;
  logic [TAG_W-1:0]        stride_a_q, stride_a_d, stride_b_q, stride_b_d;
  logic [TAG_W-1:0]        count_q, count_d, iter_q, iter_d;
  logic                    have_a_q, have_a_d, have_b_q, have_b_d;
  logic [LANES*DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [LANES*ACC_W-1:0]  acc_q, acc_d;
  logic [LANES-1:0]        sticky_q, sticky_d;
  logic                    out_valid_q, out_valid_d;
  logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]        out_sat_q, out_sat_d;
  logic                    cfg_ready_q, cfg_ready_d;
  logic                    busy_q, busy_d;

  // Per-lane results of the COMPUTE cycle, consumed by the FSM below.
  logic [LANES*ACC_W-1:0]  acc_new;
  logic [LANES-1:0]        sticky_new;
  logic [LANES*DATA_W-1:0] res_new;
  logic [LANES-1:0]        sat_new;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [DATA_W-1:0]   a, b;
    logic signed [DATA_W:0]     sum, diff, adiff;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_cur, term, acc_upd;
    logic signed [ACC_W:0]      acc_sum, rnd, shr;
    logic [ACC_W-DATA_W+1:0]    hi;
    logic                       ovf, clamp;

    assign a       = op_a_q[g*DATA_W +: DATA_W];
    assign b       = op_b_q[g*DATA_W +: DATA_W];
    assign acc_cur = acc_q[g*ACC_W +: ACC_W];
    assign sum     = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    assign diff    = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    assign adiff   = diff[DATA_W] ? -diff : diff;
    assign prod    = a * b;

    // Add/sub terms are aligned to the product's 2*FRAC_W fraction bits.
    always_comb begin
      term = '0;
      case (op_q)
        2'b00: term = ACC_W'(sum) <<< FRAC_W;
        2'b01: term = ACC_W'(diff) <<< FRAC_W;
        2'b10: term = ACC_W'(prod);
        2'b11: term = ACC_W'(adiff) <<< FRAC_W;
      endcase
    end

    // One guard bit detects accumulator overflow; clamp to the ACC_W extremes.
    assign acc_sum = {acc_cur[ACC_W-1], acc_cur} + {term[ACC_W-1], term};
    assign ovf     = acc_mode_q & (acc_sum[ACC_W] != acc_sum[ACC_W-1]);
    assign acc_upd = !acc_mode_q ? term :
                     ovf ? (acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}})
                         : acc_sum[ACC_W-1:0];

    // Round half toward +inf, then clamp when the upper bits are not a pure sign extension.
    assign rnd   = {acc_upd[ACC_W-1], acc_upd} + HALF;
    assign shr   = rnd >>> FRAC_W;
    assign hi    = shr[ACC_W:DATA_W-1];
    assign clamp = ~((&hi) | (~|hi));

    assign acc_new[g*ACC_W +: ACC_W]    = acc_upd;
    assign sticky_new[g]                = sticky_q[g] | ovf;
    assign res_new[g*DATA_W +: DATA_W]  = !clamp ? shr[DATA_W-1:0] :
                                          shr[ACC_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                     : {1'b0, {(DATA_W-1){1'b1}}};
    assign sat_new[g]                   = clamp | sticky_new[g];
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_mode_d = acc_mode_q;
    tag_a_d    = tag_a_q;
    tag_b_d    = tag_b_q;
    stride_a_d = stride_a_q;
    stride_b_d = stride_b_q;
    count_d    = count_q;
    iter_d     = iter_q;
    have_a_d   = have_a_q;
    have_b_d   = have_b_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    acc_d      = acc_q;
    sticky_d   = sticky_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          op_d       = cfg_op;
          acc_mode_d = cfg_acc;
          tag_a_d    = cfg_tag_a;
          tag_b_d    = cfg_tag_b;
          stride_a_d = cfg_stride_a;
          stride_b_d = cfg_stride_b;
          count_d    = cfg_count;
          iter_d     = '0;
          have_a_d   = 1'b0;
          have_b_d   = 1'b0;
          acc_d      = '0;
          sticky_d   = '0;
          if (cfg_count == '0) begin
            // Empty job: present a zero result straight away.
            state_d     = S_DRAIN;
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_sat_d   = '0;
          end else begin
            state_d = S_GATHER;
          end
        end
      end
      S_GATHER: begin
        if (bus_valid) begin
          // A and B compare independently so one beat can supply both.
          if (bus_tag == tag_a_q) begin
            op_a_d   = bus_data;
            have_a_d = 1'b1;
          end
          if (bus_tag == tag_b_q) begin
            op_b_d   = bus_data;
            have_b_d = 1'b1;
          end
        end
        if (have_a_d && have_b_d) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        acc_d    = acc_new;
        sticky_d = sticky_new;
        tag_a_d  = tag_a_q + stride_a_q;
        tag_b_d  = tag_b_q + stride_b_q;
        iter_d   = iter_q + TAG_W'(1);
        have_a_d = 1'b0;
        have_b_d = 1'b0;
        if (iter_d == count_q) begin
          state_d     = S_DRAIN;
          out_valid_d = 1'b1;
          out_data_d  = res_new;
          out_sat_d   = sat_new;
        end else begin
          state_d = S_GATHER;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cfg_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      acc_mode_q  <= 1'b0;
      tag_a_q     <= '0;
      tag_b_q     <= '0;
      stride_a_q  <= '0;
      stride_b_q  <= '0;
      count_q     <= '0;
      iter_q      <= '0;
      have_a_q    <= 1'b0;
      have_b_q    <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      acc_q       <= '0;
      sticky_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_mode_q  <= acc_mode_d;
      tag_a_q     <= tag_a_d;
      tag_b_q     <= tag_b_d;
      stride_a_q  <= stride_a_d;
      stride_b_q  <= stride_b_d;
      count_q     <= count_d;
      iter_q      <= iter_d;
      have_a_q    <= have_a_d;
      have_b_q    <= have_b_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_node_stripe_mac.sv
// Directed bench for node_stripe_mac: inputs driven on the falling edge,
// outputs sampled on the falling edge, expected values computed by hand.
module tb_node_stripe_mac;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid, cfg_ready, cfg_acc;
  logic [1:0]   cfg_op;
  logic [15:0]  cfg_tag_a, cfg_tag_b, cfg_stride_a, cfg_stride_b, cfg_count;
  logic         bus_valid;
  logic [15:0]  bus_tag;
  logic [127:0] bus_data;
  logic         out_valid, out_ready, busy;
  logic [127:0] out_data;
  logic [7:0]   out_sat;

  int checks = 0;
  int errors = 0;

  node_stripe_mac dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op), .cfg_acc(cfg_acc),
    .cfg_tag_a(cfg_tag_a), .cfg_tag_b(cfg_tag_b),
    .cfg_stride_a(cfg_stride_a), .cfg_stride_b(cfg_stride_b), .cfg_count(cfg_count),
    .bus_valid(bus_valid), .bus_tag(bus_tag), .bus_data(bus_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] lanes3(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] l2);
    return {80'h0, l2, l1, l0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge; the descriptor is accepted on the next rising edge.
  task automatic start(input logic [1:0] op, input logic ac, input logic [15:0] ta,
                       input logic [15:0] tbv, input logic [15:0] sa, input logic [15:0] sb,
                       input logic [15:0] cnt);
    cfg_op = op; cfg_acc = ac; cfg_tag_a = ta; cfg_tag_b = tbv;
    cfg_stride_a = sa; cfg_stride_b = sb; cfg_count = cnt;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic beat(input logic [15:0] tag, input logic [127:0] data);
    bus_tag = tag; bus_data = data; bus_valid = 1'b1;
    @(negedge clk);
    bus_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_op = '0; cfg_acc = 1'b0;
    cfg_tag_a = '0; cfg_tag_b = '0; cfg_stride_a = '0; cfg_stride_b = '0; cfg_count = '0;
    bus_valid = 1'b0; bus_tag = '0; bus_data = '0; out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_cfg_ready", 128'(cfg_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_out_sat", 128'(out_sat), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Dot product: 3 x (1.0 * 2.0) = 6.0
    start(2'b10, 1'b1, 16'h0010, 16'h0020, 16'd1, 16'd1, 16'd3);
    chk("dot_busy", 128'(busy), 128'd1);
    chk("dot_cfg_ready", 128'(cfg_ready), 128'd0);
    for (int k = 0; k < 3; k++) begin
      beat(16'h0010 + 16'(k), lanes3(16'h0100, 16'h0, 16'h0));
      beat(16'h0020 + 16'(k), lanes3(16'h0200, 16'h0, 16'h0));
      chk("dot_no_early_valid", 128'(out_valid), 128'd0);
      @(negedge clk);
    end
    chk("dot_valid_after_compute", 128'(out_valid), 128'd1);
    chk("dot_data", out_data, 128'h0600);
    chk("dot_sat", 128'(out_sat), 128'd0);
    handshake();
    chk("hs_out_valid", 128'(out_valid), 128'd0);
    chk("hs_busy", 128'(busy), 128'd0);
    chk("hs_cfg_ready", 128'(cfg_ready), 128'd1);

    // Saturation on output clamp, both polarities, plus an unsaturated lane
    start(2'b00, 1'b1, 16'h0100, 16'h0200, 16'd1, 16'd1, 16'd2);
    for (int k = 0; k < 2; k++) begin
      beat(16'h0100 + 16'(k), lanes3(16'h7F00, 16'h8000, 16'h0100));
      beat(16'h0200 + 16'(k), lanes3(16'h7F00, 16'h8000, 16'h0100));
      @(negedge clk);
    end
    chk("sat_valid", 128'(out_valid), 128'd1);
    chk("sat_data", out_data, lanes3(16'h7FFF, 16'h8000, 16'h0400));
    chk("sat_flags", 128'(out_sat), 128'h03);
    handshake();

    // Rounding with overwrite: first iteration's terms must not survive
    start(2'b10, 1'b0, 16'h0300, 16'h0400, 16'd1, 16'd1, 16'd2);
    beat(16'h0300, lanes3(16'h7F00, 16'h7F00, 16'h7F00));
    beat(16'h0400, lanes3(16'h7F00, 16'h7F00, 16'h7F00));
    @(negedge clk);
    beat(16'h0301, lanes3(16'h0001, 16'hFFFF, 16'hFFFF));
    beat(16'h0401, lanes3(16'h0080, 16'h0080, 16'h0100));
    @(negedge clk);
    chk("rnd_data", out_data, lanes3(16'h0001, 16'h0000, 16'hFFFF));
    chk("rnd_sat", 128'(out_sat), 128'd0);
    handshake();

    // Same tag for A and B: one beat fills both, |a-a| = 0
    start(2'b11, 1'b1, 16'h0040, 16'h0040, 16'd0, 16'd0, 16'd1);
    beat(16'h0040, lanes3(16'h1234, 16'h8000, 16'h7FFF));
    @(negedge clk);
    chk("same_tag_valid", 128'(out_valid), 128'd1);
    chk("same_tag_data", out_data, 128'd0);
    handshake();

    // Tag wrap: second A operand lives at tag 0x0000; (1+1)+(2+1) = 5.0
    start(2'b00, 1'b1, 16'hFFFF, 16'h0500, 16'd1, 16'd1, 16'd2);
    beat(16'hFFFF, lanes3(16'h0100, 16'h0, 16'h0));
    beat(16'h0500, lanes3(16'h0100, 16'h0, 16'h0));
    @(negedge clk);
    beat(16'h0000, lanes3(16'h0200, 16'h0, 16'h0));
    beat(16'h0501, lanes3(16'h0100, 16'h0, 16'h0));
    @(negedge clk);
    chk("wrap_valid", 128'(out_valid), 128'd1);
    chk("wrap_data", out_data, 128'h0500);
    handshake();

    // Beat during COMPUTE is dropped: (1+1)+(2+1) = 5.0, not 6.0
    start(2'b00, 1'b1, 16'h0600, 16'h0700, 16'd1, 16'd1, 16'd2);
    beat(16'h0600, lanes3(16'h0100, 16'h0, 16'h0));
    beat(16'h0700, lanes3(16'h0100, 16'h0, 16'h0));
    beat(16'h0601, lanes3(16'h0300, 16'h0, 16'h0));
    beat(16'h0701, lanes3(16'h0100, 16'h0, 16'h0));
    chk("drop_still_gathering", 128'(out_valid), 128'd0);
    beat(16'h0601, lanes3(16'h0200, 16'h0, 16'h0));
    @(negedge clk);
    chk("drop_valid", 128'(out_valid), 128'd1);
    chk("drop_data", out_data, 128'h0500);
    handshake();

    // count = 0: result the cycle after acceptance, data 0
    start(2'b10, 1'b1, 16'h0, 16'h0, 16'd0, 16'd0, 16'd0);
    chk("cnt0_valid", 128'(out_valid), 128'd1);
    chk("cnt0_data", out_data, 128'd0);
    chk("cnt0_busy", 128'(busy), 128'd1);
    handshake();

    // Backpressure: data holds, cfg_ready low, a descriptor pulse is ignored
    start(2'b10, 1'b1, 16'h0800, 16'h0900, 16'd1, 16'd1, 16'd1);
    beat(16'h0800, lanes3(16'h0100, 16'h0, 16'h0));
    beat(16'h0900, lanes3(16'h0200, 16'h0, 16'h0));
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_data", out_data, 128'h0200);
      chk("bp_cfg_ready", 128'(cfg_ready), 128'd0);
      if (i == 2) begin
        cfg_count = 16'd0;
        cfg_valid = 1'b1;
      end
      @(negedge clk);
      cfg_valid = 1'b0;
    end
    handshake();
    chk("bp_done_valid", 128'(out_valid), 128'd0);
    chk("bp_done_busy", 128'(busy), 128'd0);

    // Reset mid-GATHER with only A captured
    start(2'b00, 1'b1, 16'h0A00, 16'h0B00, 16'd0, 16'd0, 16'd1);
    beat(16'h0A00, lanes3(16'h7000, 16'h0, 16'h0));
    chk("mid_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_cfg_ready", 128'(cfg_ready), 128'd1);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start(2'b00, 1'b1, 16'h0A00, 16'h0B00, 16'd0, 16'd0, 16'd1);
    beat(16'h0B00, lanes3(16'h0100, 16'h0, 16'h0));
    @(negedge clk);
    chk("post_rst_no_stale", 128'(out_valid), 128'd0);
    beat(16'h0A00, lanes3(16'h0100, 16'h0, 16'h0));
    @(negedge clk);
    chk("post_rst_valid", 128'(out_valid), 128'd1);
    chk("post_rst_data", out_data, 128'h0200);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/node_stripe_mac.md
# node_stripe_mac

Parametrised successor of the fixed 8-lane node stripe: `LANES` signed fixed-point processing lanes that share one tag-matching front end. The block takes a job descriptor through a `cfg` handshake and snoops a broadcast operand bus for beats whose tags match the current A/B tags, advancing both tags by their strides each iteration. It runs a per-lane add/sub/MAC/abs-diff accumulation over `cfg_count` iterations, then presents a rounded, saturated result through a valid/ready output with backpressure. It sits between the node router's broadcast bus and the node's result path.

## Interface
- `LANES`, 8, number of lanes.
- `DATA_W`, 16, signed operand/result width per lane.
- `FRAC_W`, 8, fractional bits of operands and results; must be 1..DATA_W-1.
- `ACC_W`, 40, signed accumulator width; must be ≥ 2·DATA_W+1.
- `TAG_W`, 16, tag, stride and count width.
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `cfg_valid` in 1 / `cfg_ready` out 1: descriptor handshake.
- `cfg_op` in 2: 00 a+b, 01 a−b, 10 a·b, 11 |a−b|.
- `cfg_acc` in 1: 1 accumulates terms; 0 makes each iteration overwrite acc.
- `cfg_tag_a`, `cfg_tag_b`, `cfg_stride_a`, `cfg_stride_b`, `cfg_count` in TAG_W each.
- `bus_valid` in 1, `bus_tag` in TAG_W, `bus_data` in LANES·DATA_W: broadcast operand beat. Lane i uses bits [i·DATA_W +: DATA_W].
- `out_valid` out 1, `out_ready` in 1, `out_data` out LANES·DATA_W: result.
- `out_sat` out LANES: per-lane saturation flag.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, GATHER, COMPUTE, DRAIN.
- IDLE: `cfg_ready`=1. On `cfg_valid`:
  - latch the descriptor; clear acc, sticky sat flags, iteration counter, `have_a` and `have_b`.
  - go to GATHER; if `cfg_count`=0, go straight to DRAIN with acc=0.
- GATHER: on `bus_valid`:
  - `bus_tag`==tag_a captures all lanes into opA and sets `have_a`.
  - `bus_tag`==tag_b captures into opB and sets `have_b`.
  - Both compare independently, so one beat can fill both.
  - A repeat match overwrites (last wins).
  - When both are present after this beat's update, go to COMPUTE.
- COMPUTE (exactly 1 cycle), per lane:
  - Form term t: add/sub operands are sign-extended and shifted left by FRAC_W; the product is used as is. Acc therefore carries 2·FRAC_W fraction bits.
  - acc ← sat_ACC_W(acc + t) if `cfg_acc`, else t.
  - ACC_W overflow clamps to the ACC_W max/min and sets the sticky sat flag.
  - Also: tag_a += stride_a, tag_b += stride_b (modulo 2^TAG_W); iteration counter +1; clear have flags.
  - If the counter reaches `cfg_count`, go to DRAIN; else return to GATHER.
  - Bus beats arriving during COMPUTE are dropped.
- DRAIN, per lane, registered on entry:
  - r = (acc + 2^(FRAC_W−1)) >>> FRAC_W, i.e. round to nearest, ties toward +∞.
  - Clamp r to the signed DATA_W range.
  - `out_sat[i]` = clamp occurred OR sticky flag set.
  - Hold `out_valid`=1 with stable data until `out_ready`; on the handshake go to IDLE.
- `cfg_valid` outside IDLE is ignored.

## Timing
- Reset (async, immediate): state IDLE, `cfg_ready`=1, `busy`=0, `out_valid`=0, `out_data`=0, `out_sat`=0, acc/tags/counter/have flags 0. Any job in flight is discarded.
- Descriptor accepted at edge E: GATHER from E (`busy`=1 the next cycle).
- Beat completing a pair at edge E: COMPUTE during cycle E..E+1. Next GATHER or DRAIN from E+1.
- Final COMPUTE ends at edge F: `out_valid`=1 from F.
- Output handshake at edge H: IDLE from H. A new `cfg_valid` is accepted at H+1 at the earliest.
- Minimum throughput: 2 cycles per iteration (one GATHER beat plus COMPUTE).
- `count`=0: `out_valid` the cycle after `cfg` acceptance, data 0.

## Test plan
- Dot product, op=10, acc=1, count=3, tag_a=0x0010/stride 1, tag_b=0x0020/stride 1. Lane0 a=0x0100 (1.0), b=0x0200 (2.0) every beat. Expected: lane0 `out_data` 0x0600, `out_sat`=0, `out_valid` exactly 1 cycle after the 3rd COMPUTE.
- Saturation, op=00, acc=1, count=2. Lane0 a=b=0x7F00 expects 0x7FFF, sat=1. Lane1 a=b=0x8000 expects 0x8000, sat=1. Lane2 a=b=0x0100 expects 0x0400, sat=0.
- Rounding, op=10, acc=0, count=1.
  - a=0x0001, b=0x0080 expects 0x0001 (tie rounds up).
  - a=0xFFFF, b=0x0080 expects 0x0000.
  - a=0xFFFF, b=0x0100 expects 0xFFFF.
- Tag corner cases:
  - tag_a=tag_b=0x0040, stride 0, op=11: a single beat fills both operands; result 0.
  - tag_a=0xFFFF, stride 1, count=2: the second A operand is matched at tag 0x0000.
  - A matching beat presented during COMPUTE is dropped: the result excludes it.
- Backpressure and `count`=0:
  - count=0 gives `out_valid` the cycle after acceptance, data 0.
  - Hold `out_ready`=0 for 5 cycles: data stable, `cfg_ready`=0, a `cfg_valid` pulse is ignored.
- Reset mid-GATHER, after one operand captured: `busy`=0, `cfg_ready`=1, `out_valid`=0 immediately. A new job then completes correctly with no stale operand.
